uart_hex_word_tx: RTL and testbench

Transmit-side counterpart of the UART hex-nibble loader. Accepts a 32-bit word over a valid/ready handshake and streams it to the UART transmitter as 8 ASCII hex characters, MSB nibble first, optionally followed by CR LF. Drives the UART core's din/wr_en pins and paces itself on tx_busy. Sits beside the loader in the top level so loaded instruction words or debug values can be read back to the PC.

---
 rtl/uart_pkg.sv | 17 +
 rtl/nibble_to_ascii.sv | 18 +
 rtl/uart_hex_word_tx.sv | 101 ++++++++++
 tb/tb_uart_hex_word_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART-side constants and the hex word transmitter state encoding.
package uart_pkg;

  localparam logic [7:0] CHAR_CR      = 8'h0D;
  localparam logic [7:0] CHAR_LF      = 8'h0A;
  localparam logic [7:0] ASCII_0      = 8'h30;
  localparam logic [7:0] ASCII_UC_OFS = 8'h37;
  localparam logic [7:0] ASCII_LC_OFS = 8'h57;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GUARD = 2'd2,
    ST_WAIT  = 2'd3
  } hex_tx_state_e;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit nibble to ASCII hex digit encoder.
module nibble_to_ascii
  import uart_pkg::*;
#(
  parameter bit UPPERCASE = 1'b1
) (
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    ascii_o = ASCII_0 + {4'h0, nibble_i};
    if (nibble_i >= 4'd10) begin
      ascii_o = (UPPERCASE ? ASCII_UC_OFS : ASCII_LC_OFS) + {4'h0, nibble_i};
    end
  end

endmodule

// File: rtl/uart_hex_word_tx.sv
// Streams a 32-bit word to the UART core as 8 ASCII hex chars (MSB first),
// optionally followed by CR LF, pacing each byte on tx_busy.
//
// state | meaning
// IDLE  | waiting for word_valid, word_ready high
// ISSUE | strobe current char into UART core once tx_busy is low
// GUARD | one cycle ignoring tx_busy while the core raises it
// WAIT  | wait for tx_busy to fall, then next char or finish
module uart_hex_word_tx
  import uart_pkg::*;
#(
  parameter bit SEND_CRLF = 1'b1,
  parameter bit UPPERCASE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic [7:0]  tx_din,
  output logic        tx_wr_en,
  input  logic        tx_busy,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] LAST_IDX = SEND_CRLF ? 4'd9 : 4'd7;

  hex_tx_state_e state_q;
  logic [31:0]   shift_q;
  logic [3:0]    idx_q;
  logic [7:0]    din_q;

  logic [3:0]    nib_sel;
  logic [7:0]    nib_ascii;
  logic [3:0]    idx_d;
  logic [7:0]    char_d;

  // The first char is encoded straight from word_in at accept, so the shift
  // register always holds the next nibble to send in its top bits.
  assign nib_sel = (state_q == ST_IDLE) ? word_in[31:28] : shift_q[31:28];

  nibble_to_ascii #(.UPPERCASE(UPPERCASE)) u_nib2asc (
    .nibble_i (nib_sel),
    .ascii_o  (nib_ascii)
  );

  assign idx_d = idx_q + 4'd1;

  always_comb begin
    char_d = nib_ascii;
    if (idx_d == 4'd8) char_d = CHAR_CR;
    if (idx_d == 4'd9) char_d = CHAR_LF;
  end

  assign word_ready = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign tx_din     = din_q;
  assign tx_wr_en   = (state_q == ST_ISSUE) && !tx_busy;
  assign done       = (state_q == ST_WAIT) && !tx_busy && (idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= 32'h0;
      idx_q   <= 4'd0;
      din_q   <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (word_valid) begin
            shift_q <= {word_in[27:0], 4'h0};
            idx_q   <= 4'd0;
            din_q   <= nib_ascii;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!tx_busy) state_q <= ST_GUARD;
        end
        ST_GUARD: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!tx_busy) begin
            if (idx_q == LAST_IDX) begin
              state_q <= ST_IDLE;
            end else begin
              idx_q   <= idx_d;
              din_q   <= char_d;
              if (idx_q < 4'd7) shift_q <= {shift_q[27:0], 4'h0};
              state_q <= ST_ISSUE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_hex_word_tx.sv
// Randomized self-checking bench: two DUT builds driven against simple UART core models.
module tb_uart_hex_word_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] a_word, b_word;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready, a_wr, b_wr, a_busy, b_busy, a_done, b_done;
  logic [7:0]  a_din, b_din;
  logic        a_tbusy, b_tbusy;

  int   a_len = 20, b_len = 20;
  bit   a_force = 1'b0;
  int   a_cnt = 0, b_cnt = 0;
  bit   a_lat = 1'b0, b_lat = 1'b0;
  logic [7:0] a_cap[$], b_cap[$];
  int   a_scyc[$];
  int   a_ndone = 0, b_ndone = 0, a_dcyc = 0, cyc = 0;
  logic [7:0] exp_q[$];
  int   tests = 0, fails = 0;

  assign a_tbusy = a_force || (a_cnt != 0);
  assign b_tbusy = (b_cnt != 0);

  uart_hex_word_tx #(.SEND_CRLF(1'b1), .UPPERCASE(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .word_in(a_word), .word_valid(a_valid), .word_ready(a_ready),
    .tx_din(a_din), .tx_wr_en(a_wr), .tx_busy(a_tbusy), .busy(a_busy), .done(a_done));

  uart_hex_word_tx #(.SEND_CRLF(1'b0), .UPPERCASE(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .word_in(b_word), .word_valid(b_valid), .word_ready(b_ready),
    .tx_din(b_din), .tx_wr_en(b_wr), .tx_busy(b_tbusy), .busy(b_busy), .done(b_done));

  // UART core model: busy rises one cycle after wr_en and lasts len cycles.
  always @(posedge clk) begin
    if (a_wr) begin a_cap.push_back(a_din); a_scyc.push_back(cyc); end
    if (b_wr) b_cap.push_back(b_din);
    if (a_done) begin a_ndone++; a_dcyc = cyc; end
    if (b_done) b_ndone++;
    if (rst) begin
      a_lat <= 1'b0; a_cnt <= 0; b_lat <= 1'b0; b_cnt <= 0;
    end else begin
      if (a_wr) a_lat <= 1'b1;
      else if (a_lat) begin a_lat <= 1'b0; a_cnt <= a_len; end
      else if (a_cnt > 0) a_cnt <= a_cnt - 1;
      if (b_wr) b_lat <= 1'b1;
      else if (b_lat) begin b_lat <= 1'b0; b_cnt <= b_len; end
      else if (b_cnt > 0) b_cnt <= b_cnt - 1;
    end
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: hex digits of the word, most significant first, then optional CR LF.
  task automatic model_word(input logic [31:0] w, input bit uc, input bit crlf);
    for (int i = 0; i < 8; i++) begin
      int n;
      n = int'((w >> (28 - 4 * i)) & 32'hF);
      if (n < 10) exp_q.push_back(8'(48 + n));
      else exp_q.push_back(8'((uc ? 65 : 97) + n - 10));
    end
    if (crlf) begin exp_q.push_back(8'd13); exp_q.push_back(8'd10); end
  endtask

  function automatic logic get_ready(input bit sel);
    return sel ? b_ready : a_ready;
  endfunction
  function automatic logic get_busy(input bit sel);
    return sel ? b_busy : a_busy;
  endfunction
  function automatic int cap_size(input bit sel);
    return sel ? b_cap.size() : a_cap.size();
  endfunction
  function automatic logic [7:0] cap_at(input bit sel, input int i);
    return sel ? b_cap[i] : a_cap[i];
  endfunction
  function automatic int ndone(input bit sel);
    return sel ? b_ndone : a_ndone;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [31:0] w);
    if (sel) begin b_valid = v; b_word = w; end
    else begin a_valid = v; a_word = w; end
  endtask

  task automatic wait_accept(input bit sel, output int acc);
    acc = -1;
    for (int k = 0; k < 3000; k++) begin
      if (get_ready(sel)) begin acc = cyc; return; end
      @(negedge clk);
    end
    check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input bit sel, input int target);
    for (int k = 0; k < 5000; k++) begin
      if (ndone(sel) >= target) return;
      @(negedge clk);
    end
    check("done_timeout", ndone(sel), target);
  endtask

  task automatic compare(input bit sel, input int base);
    check("byte_count", cap_size(sel) - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < cap_size(sel); i++)
      check($sformatf("byte%0d", i), cap_at(sel, base + i), exp_q[i]);
  endtask

  task automatic send_word(input bit sel, input logic [31:0] w, input int len, input bit do_lat);
    int base, sbase, nd0, acc;
    if (sel) b_len = len; else a_len = len;
    exp_q.delete();
    model_word(w, !sel, !sel);
    base = cap_size(sel); sbase = a_scyc.size(); nd0 = ndone(sel);
    @(negedge clk); drive(sel, 1'b1, w);
    wait_accept(sel, acc);
    @(negedge clk); drive(sel, 1'b0, w);
    wait_done(sel, nd0 + 1);
    check("ready_after_done", get_ready(sel), 1'b1);
    check("busy_after_done", get_busy(sel), 1'b0);
    repeat (3) @(negedge clk);
    check("done_pulses", ndone(sel) - nd0, 1);
    compare(sel, base);
    if (do_lat && !sel && a_scyc.size() > sbase)
      check("first_strobe_lat", a_scyc[sbase] - acc, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, sbase, nd0, acc1, acc2, n3;
    rst = 1'b1;
    drive(0, 1'b0, 32'h0); drive(1, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_ready", a_ready, 1'b1);
    check("rst_busy", a_busy, 1'b0);
    check("rst_wr", a_wr, 1'b0);
    check("rst_din", a_din, 8'h00);
    check("rst_done", a_done, 1'b0);
    check("rst_ready_b", b_ready, 1'b1);
    rst = 1'b0;

    send_word(0, 32'hDEADBEEF, 20, 1'b1);
    send_word(1, 32'h0000A00F, 7, 1'b0);

    // tx_busy held at accept; a second word_valid mid-send must be ignored
    a_len = 6; exp_q.delete(); model_word(32'h12345678, 1, 1);
    base = a_cap.size(); nd0 = a_ndone;
    a_force = 1'b1;
    @(negedge clk); drive(0, 1'b1, 32'h12345678);
    @(negedge clk); drive(0, 1'b0, 32'h12345678);
    repeat (20) @(negedge clk);
    drive(0, 1'b1, 32'hFFFFFFFF);
    check("held_not_ready", a_ready, 1'b0);
    repeat (5) @(negedge clk);
    drive(0, 1'b0, 32'hFFFFFFFF);
    repeat (25) @(negedge clk);
    check("held_no_strobe", a_cap.size() - base, 0);
    check("held_busy", a_busy, 1'b1);
    a_force = 1'b0;
    wait_done(0, nd0 + 1);
    repeat (3) @(negedge clk);
    check("held_done_pulses", a_ndone - nd0, 1);
    compare(0, base);

    // back-to-back words with word_valid held
    a_len = 20; exp_q.delete();
    model_word(32'h01234567, 1, 1); model_word(32'h89ABCDEF, 1, 1);
    base = a_cap.size(); sbase = a_scyc.size(); nd0 = a_ndone;
    @(negedge clk); drive(0, 1'b1, 32'h01234567);
    wait_accept(0, acc1);
    @(negedge clk); drive(0, 1'b1, 32'h89ABCDEF);
    wait_accept(0, acc2);
    check("b2b_accept_after_done", acc2, a_dcyc + 1);
    @(negedge clk); drive(0, 1'b0, 32'h0);
    wait_done(0, nd0 + 2);
    compare(0, base);
    if (a_scyc.size() - sbase == 20)
      for (int i = 1; i < 20; i++)
        check($sformatf("b2b_gap%0d", i), a_scyc[sbase + i] - a_scyc[sbase + i - 1],
              (i == 10) ? a_len + 4 : a_len + 3);

    // reset after the third byte aborts the word
    a_len = 20; exp_q.delete(); model_word(32'hCAFEF00D, 1, 1);
    base = a_cap.size();
    @(negedge clk); drive(0, 1'b1, 32'hCAFEF00D);
    wait_accept(0, acc1);
    @(negedge clk); drive(0, 1'b0, 32'h0);
    for (int k = 0; k < 3000; k++) begin
      if (a_cap.size() - base >= 3) break;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", a_ready, 1'b1);
    check("abort_busy", a_busy, 1'b0);
    check("abort_din", a_din, 8'h00);
    n3 = a_cap.size() - base;
    repeat (100) @(negedge clk);
    check("abort_no_more_wr", a_cap.size() - base, 3);
    for (int i = 0; i < 3 && i < n3; i++)
      check($sformatf("abort_byte%0d", i), a_cap[base + i], exp_q[i]);
    send_word(0, 32'h00000001, 5, 1'b1);

    for (int r = 0; r < 6; r++)
      send_word(0, $urandom, $urandom_range(1, 25), 1'b1);
    for (int r = 0; r < 4; r++)
      send_word(1, $urandom, $urandom_range(1, 25), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
